// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file
// writeback arbiter and its busy scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } arb_state_e;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register busy bits for MDU results in flight,
// with read ports and double-issue detection.
module regfile_scoreboard #(
  parameter int REG_NUM = regfile_wb_arbiter_pkg::REG_NUM,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              chk_busy,
  output logic              dbl_iss
);

  logic [REG_NUM-1:0] r_busy;
  logic               w_set_ok;
  logic               w_clr_same;

  assign w_set_ok   = set_en && (set_addr != '0);
  assign w_clr_same = clr_en && (clr_addr == set_addr);

  assign busy1    = r_busy[rd_addr1];
  assign busy2    = r_busy[rd_addr2];
  assign chk_busy = r_busy[chk_addr];

  // A completion in the same cycle retires the old owner first.
  assign dbl_iss = w_set_ok && r_busy[set_addr] && !w_clr_same;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (w_set_ok && (set_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if (clr_en && (clr_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b0;
      end
      r_busy[0] <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter between pipeline writeback and the MDU,
// with starvation hold and busy scoreboard.
module regfile_wb_arbiter #(
  parameter int REG_NUM      = regfile_wb_arbiter_pkg::REG_NUM,
  parameter int ADDR_W       = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W       = regfile_wb_arbiter_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_waddr,
  input  logic [ADDR_W-1:0] rdaddr1,
  input  logic [ADDR_W-1:0] rdaddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              wb_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wraddr,
  output logic [DATA_W-1:0] wrdata,
  output logic              sb_err
);

  import regfile_wb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_lose;
  logic w_grant;
  logic w_wb_busy;
  logic w_dbl_iss;
  logic w_err;

  assign w_lose    = mdu_valid & wb_we;
  assign w_grant   = mdu_valid & ~wb_we;
  assign mdu_ready = w_grant;
  assign wb_hold   = (r_state == S_HOLD);
  assign sb_err    = r_err;

  regfile_scoreboard #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_valid),
    .set_addr (iss_waddr),
    .clr_en   (w_grant),
    .clr_addr (mdu_waddr),
    .rd_addr1 (rdaddr1),
    .rd_addr2 (rdaddr2),
    .chk_addr (wb_waddr),
    .busy1    (busy1),
    .busy2    (busy2),
    .chk_busy (w_wb_busy),
    .dbl_iss  (w_dbl_iss)
  );

  always_comb begin
    wr_en  = 1'b0;
    wraddr = '0;
    wrdata = ZERO_WORD;
    unique case (1'b1)
      wb_we: begin
        wr_en  = 1'b1;
        wraddr = wb_waddr;
        wrdata = wb_wdata;
      end
      w_grant: begin
        wr_en  = 1'b1;
        wraddr = mdu_waddr;
        wrdata = mdu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_lose) begin
            r_cnt   <= CNT_W'(1);
            r_state <= (STARVE_LIMIT <= 1) ? S_HOLD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_lose) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt >= CNT_W'(STARVE_LIMIT - 1))
              r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!w_lose) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_err = w_dbl_iss
               | (wb_we & w_wb_busy)
               | (wb_we & (r_state == S_HOLD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_err)
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: priority, grant,
// starvation hold, scoreboard and reset behaviour.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic [4:0]  rdaddr1;
  logic [4:0]  rdaddr2;
  logic        busy1;
  logic        busy2;
  logic        wb_hold;
  logic        wr_en;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  logic        sb_err;

  int n_tests;
  int n_fail;

  regfile_wb_arbiter #(
    .REG_NUM      (32),
    .ADDR_W       (5),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .mdu_valid (mdu_valid),
    .mdu_waddr (mdu_waddr),
    .mdu_wdata (mdu_wdata),
    .mdu_ready (mdu_ready),
    .iss_valid (iss_valid),
    .iss_waddr (iss_waddr),
    .rdaddr1   (rdaddr1),
    .rdaddr2   (rdaddr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .wb_hold   (wb_hold),
    .wr_en     (wr_en),
    .wraddr    (wraddr),
    .wrdata    (wrdata),
    .sb_err    (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    wb_we     = 1'b0;
    wb_waddr  = '0;
    wb_wdata  = '0;
    mdu_valid = 1'b0;
    mdu_waddr = '0;
    mdu_wdata = '0;
    iss_valid = 1'b0;
    iss_waddr = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    rdaddr1 = 5'd0;
    rdaddr2 = 5'd0;
    tick();
    tick();
    #1;
    n_tests++;
    if (wb_hold !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold got %b exp 0", wb_hold);
    end
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %b exp 0", sb_err);
    end
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_en got %b exp 0", wr_en);
    end
    n_tests++;
    if (wraddr !== 5'd0 || wrdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle_port got %h/%h exp 0/0", wraddr, wrdata);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wb_priority;
    wb_we    = 1'b1;
    wb_waddr = 5'd5;
    wb_wdata = 32'hA5A5_A5A5;
    #1;
    n_tests++;
    if (wr_en !== 1'b1) begin
      n_fail++; $display("FAIL wb_wr_en got %b exp 1", wr_en);
    end
    n_tests++;
    if (wraddr !== 5'd5) begin
      n_fail++; $display("FAIL wb_wraddr got %0d exp 5", wraddr);
    end
    n_tests++;
    if (wrdata !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL wb_wrdata got %h exp a5a5a5a5", wrdata);
    end
    n_tests++;
    if (mdu_ready !== 1'b0) begin
      n_fail++; $display("FAIL wb_mdu_ready got %b exp 0", mdu_ready);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (wr_en !== 1'b0 || wraddr !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_port got %b/%0d exp 0/0", wr_en, wraddr);
    end
  endtask

  task automatic test_mdu_grant;
    iss_valid = 1'b1;
    iss_waddr = 5'd8;
    tick();
    iss_valid = 1'b0;
    rdaddr1   = 5'd8;
    #1;
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL grant_busy_set got %b exp 1", busy1);
    end
    mdu_valid = 1'b1;
    mdu_waddr = 5'd8;
    mdu_wdata = 32'h1234_5678;
    #1;
    n_tests++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("FAIL grant_ready got %b exp 1", mdu_ready);
    end
    n_tests++;
    if (wr_en !== 1'b1 || wraddr !== 5'd8 || wrdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL grant_port got %b/%0d/%h exp 1/8/12345678",
               wr_en, wraddr, wrdata);
    end
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL grant_no_fwd got %b exp 1", busy1);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL grant_busy_clr got %b exp 0", busy1);
    end
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL grant_err got %b exp 0", sb_err);
    end
  endtask

  task automatic test_starvation;
    iss_valid = 1'b1;
    iss_waddr = 5'd10;
    tick();
    iss_valid = 1'b0;
    mdu_valid = 1'b1;
    mdu_waddr = 5'd10;
    mdu_wdata = 32'hCAFE_0010;
    wb_we     = 1'b1;
    wb_waddr  = 5'd1;
    wb_wdata  = 32'h1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (wb_hold !== 1'b0 || mdu_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_lost%0d got hold=%b rdy=%b exp 0/0",
                 i, wb_hold, mdu_ready);
      end
      tick();
    end
    #1;
    n_tests++;
    if (wb_hold !== 1'b1) begin
      n_fail++; $display("FAIL starve_hold got %b exp 1", wb_hold);
    end
    wb_we = 1'b0;
    #1;
    n_tests++;
    if (mdu_ready !== 1'b1 || wraddr !== 5'd10) begin
      n_fail++;
      $display("FAIL starve_grant got %b/%0d exp 1/10", mdu_ready, wraddr);
    end
    tick();
    clear_inputs();
    rdaddr2 = 5'd10;
    #1;
    n_tests++;
    if (wb_hold !== 1'b0) begin
      n_fail++; $display("FAIL starve_release got %b exp 0", wb_hold);
    end
    n_tests++;
    if (busy2 !== 1'b0) begin
      n_fail++; $display("FAIL starve_busy_clr got %b exp 0", busy2);
    end
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL starve_err got %b exp 0", sb_err);
    end
  endtask

  task automatic test_set_clear_same;
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    tick();
    mdu_valid = 1'b1;
    mdu_waddr = 5'd9;
    mdu_wdata = 32'h99;
    tick();
    clear_inputs();
    rdaddr1 = 5'd9;
    #1;
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL setclr_busy got %b exp 1", busy1);
    end
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL setclr_err got %b exp 0", sb_err);
    end
    mdu_valid = 1'b1;
    mdu_waddr = 5'd9;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL setclr_final got %b exp 0", busy1);
    end
  endtask

  task automatic test_double_issue;
    iss_valid = 1'b1;
    iss_waddr = 5'd7;
    tick();
    tick();
    clear_inputs();
    rdaddr1 = 5'd7;
    #1;
    n_tests++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL dbl_err got %b exp 1", sb_err);
    end
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL dbl_busy got %b exp 1", busy1);
    end
    tick();
    tick();
    n_tests++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL dbl_sticky got %b exp 1", sb_err);
    end
    iss_valid = 1'b1;
    iss_waddr = 5'd0;
    tick();
    clear_inputs();
    rdaddr1 = 5'd0;
    #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reg0_busy got %b exp 0", busy1);
    end
  endtask

  task automatic test_reset_in_hold;
    for (int i = 11; i <= 13; i++) begin
      iss_valid = 1'b1;
      iss_waddr = 5'(i);
      tick();
    end
    clear_inputs();
    mdu_valid = 1'b1;
    mdu_waddr = 5'd11;
    mdu_wdata = 32'h0B0B_0B0B;
    wb_we     = 1'b1;
    wb_waddr  = 5'd2;
    rdaddr1   = 5'd11;
    rdaddr2   = 5'd12;
    repeat (4) tick();
    #1;
    n_tests++;
    if (wb_hold !== 1'b1) begin
      n_fail++; $display("FAIL rsthold_pre got %b exp 1", wb_hold);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (wb_hold !== 1'b0) begin
      n_fail++; $display("FAIL rsthold_hold got %b exp 0", wb_hold);
    end
    n_tests++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL rsthold_busy got %b%b exp 00", busy1, busy2);
    end
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL rsthold_err got %b exp 0", sb_err);
    end
    n_tests++;
    if (wr_en !== 1'b1 || mdu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rsthold_port got %b/%b exp 1/0", wr_en, mdu_ready);
    end
    wb_we = 1'b0;
    #1;
    n_tests++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsthold_rdy_in_rst got %b exp 1", mdu_ready);
    end
    wb_we = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    #1;
    n_tests++;
    if (wb_hold !== 1'b0) begin
      n_fail++; $display("FAIL rearb_wait got %b exp 0", wb_hold);
    end
    wb_we = 1'b0;
    #1;
    n_tests++;
    if (mdu_ready !== 1'b1 || wraddr !== 5'd11) begin
      n_fail++;
      $display("FAIL rearb_grant got %b/%0d exp 1/11", mdu_ready, wraddr);
    end
    tick();
    clear_inputs();
    rdaddr1 = 5'd13;
    #1;
    n_tests++;
    if (wb_hold !== 1'b0 || sb_err !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rearb_done got hold=%b err=%b busy=%b exp 0/0/0",
               wb_hold, sb_err, busy1);
    end
  endtask

  task automatic test_hold_wb_err;
    mdu_valid = 1'b1;
    mdu_waddr = 5'd3;
    mdu_wdata = 32'h33;
    wb_we     = 1'b1;
    wb_waddr  = 5'd4;
    repeat (4) tick();
    #1;
    n_tests++;
    if (wb_hold !== 1'b1 || sb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL holderr_pre got %b/%b exp 1/0", wb_hold, sb_err);
    end
    tick();
    n_tests++;
    if (sb_err !== 1'b1 || wb_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL holderr_set got err=%b hold=%b exp 1/1", sb_err, wb_hold);
    end
    wb_we = 1'b0;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (wb_hold !== 1'b0) begin
      n_fail++; $display("FAIL holderr_exit got %b exp 0", wb_hold);
    end
  endtask

  task automatic test_wb_busy_err;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    iss_valid = 1'b1;
    iss_waddr = 5'd14;
    tick();
    iss_valid = 1'b0;
    n_tests++;
    if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL wbbusy_pre got %b exp 0", sb_err);
    end
    wb_we    = 1'b1;
    wb_waddr = 5'd14;
    wb_wdata = 32'hEE;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (sb_err !== 1'b1) begin
      n_fail++; $display("FAIL wbbusy_err got %b exp 1", sb_err);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_wb_priority();
    test_mdu_grant();
    test_starvation();
    test_set_clear_same();
    test_double_issue();
    test_reset_in_hold();
    test_hold_wb_err();
    test_wb_busy_err();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
